// File: rtl/trig_pkg.sv
// Shared widths, FSM state encoding and angle constants for the trig scheduler.
package trig_pkg;
  localparam int ANGLE_W = 10;
  localparam int VAL_W   = 21;
  localparam int DEG_90  = 90;
  localparam int DEG_180 = 180;
  localparam int DEG_360 = 360;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } trig_state_t;
endpackage

// File: rtl/trig_lut.sv
// Combinational sine/cosine table for integer degrees, scaled by 10^PRECISE.
// Cosine reuses the sine fold as sin(90 - angle); one quadrant is stored.
module trig_lut #(
  parameter int PRECISE = 3,
  parameter int ANGLE_W = trig_pkg::ANGLE_W,
  parameter int VAL_W   = trig_pkg::VAL_W
) (
  input  logic signed [ANGLE_W-1:0] i_angle,
  output logic signed [VAL_W-1:0]   o_sine,
  output logic signed [VAL_W-1:0]   o_cosine
);
  import trig_pkg::*;

  // sin(0..90 deg) x 1e6; rescaled to 10^PRECISE with round-half-up at elaboration.
  localparam int SIN_MICRO [0:90] = '{
         0,  17452,  34899,  52336,  69756,  87156, 104528, 121869, 139173, 156434,
    173648, 190809, 207912, 224951, 241922, 258819, 275637, 292372, 309017, 325568,
    342020, 358368, 374607, 390731, 406737, 422618, 438371, 453990, 469472, 484810,
    500000, 515038, 529919, 544639, 559193, 573576, 587785, 601815, 615661, 629320,
    642788, 656059, 669131, 681998, 694658, 707107, 719340, 731354, 743145, 754710,
    766044, 777146, 788011, 798636, 809017, 819152, 829038, 838671, 848048, 857167,
    866025, 874620, 882948, 891007, 898794, 906308, 913545, 920505, 927184, 933580,
    939693, 945519, 951057, 956305, 961262, 965926, 970296, 974370, 978148, 981627,
    984808, 987688, 990268, 992546, 994522, 996195, 997564, 998630, 999391, 999848,
    1000000
  };

  function automatic longint scale(longint micro);
    longint p;
    p = 1;
    for (int i = 0; i < PRECISE; i++) p = p * 10;
    return (micro * p + 64'sd500000) / 64'sd1000000;
  endfunction

  // Folds a degree value in -180..180 onto the 0..90 table index; -1 when out of range.
  function automatic int fold_idx(int d);
    int m;
    m = (d < 0) ? -d : d;
    if (m > DEG_90) m = DEG_180 - m;
    return (m < 0 || m > DEG_90) ? -1 : m;
  endfunction

  logic signed [VAL_W-1:0] w_tab [0:90];

  for (genvar g = 0; g <= 90; g++) begin : g_tab
    assign w_tab[g] = VAL_W'(scale(longint'(SIN_MICRO[g])));
  end

  int                      w_deg_s;
  int                      w_deg_c;
  int                      w_idx_s;
  int                      w_idx_c;
  logic signed [VAL_W-1:0] w_mag_s;
  logic signed [VAL_W-1:0] w_mag_c;

  always_comb begin
    w_deg_s = int'(i_angle);
    w_deg_c = DEG_90 - w_deg_s;
    if (w_deg_c > DEG_180) w_deg_c = w_deg_c - DEG_360;
    w_idx_s = fold_idx(w_deg_s);
    w_idx_c = fold_idx(w_deg_c);
    w_mag_s = (w_idx_s < 0) ? '0 : w_tab[w_idx_s[6:0]];
    w_mag_c = (w_idx_c < 0) ? '0 : w_tab[w_idx_c[6:0]];
    o_sine   = (w_deg_s < 0) ? -w_mag_s : w_mag_s;
    o_cosine = (w_deg_c < 0) ? -w_mag_c : w_mag_c;
  end
endmodule

// File: rtl/trig_scheduler.sv
// Round-robin front end that shares one trig_lut among NUM_REQ requesters,
// returning each result with a per-requester valid/ack handshake.
module trig_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int PRECISE = 3,
  parameter int ANGLE_W = trig_pkg::ANGLE_W,
  parameter int VAL_W   = trig_pkg::VAL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ANGLE_W-1:0] angle_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ack,
  output logic signed [VAL_W-1:0]    sine,
  output logic signed [VAL_W-1:0]    cosine,
  output logic                       busy
);
  import trig_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOOKUP = LOOKUP;
  localparam logic [1:0] ST_RESP   = RESP;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [1:0]                r_state;
  logic [PTR_W-1:0]          r_rr_ptr;
  logic [PTR_W-1:0]          r_owner;
  logic signed [ANGLE_W-1:0] r_angle;
  logic signed [VAL_W-1:0]   r_sine;
  logic signed [VAL_W-1:0]   r_cosine;

  logic [NUM_REQ-1:0]        w_req_rot;
  logic                      w_found;
  logic [PTR_W-1:0]          w_sel;
  logic [PTR_W-1:0]          w_next_ptr;
  logic signed [ANGLE_W-1:0] w_angle_sel;
  logic signed [VAL_W-1:0]   w_lut_sin;
  logic signed [VAL_W-1:0]   w_lut_cos;
  logic                      w_grant_en;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  always_comb begin
    w_req_rot = NUM_REQ'({req, req} >> r_rr_ptr);
    w_found   = 1'b0;
    w_sel     = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'((int'(r_rr_ptr) + j) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_angle_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == PTR_W'(i)) w_angle_sel = angle_in[i*ANGLE_W +: ANGLE_W];
    end
  end

  assign w_next_ptr = (int'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + 1'b1;

  trig_lut #(
    .PRECISE (PRECISE),
    .ANGLE_W (ANGLE_W),
    .VAL_W   (VAL_W)
  ) u_lut (
    .i_angle  (r_angle),
    .o_sine   (w_lut_sin),
    .o_cosine (w_lut_cos)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_angle  <= '0;
      r_sine   <= '0;
      r_cosine <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner  <= w_sel;
            r_angle  <= w_angle_sel;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_sine   <= w_lut_sin;
          r_cosine <= w_lut_cos;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ack[r_owner]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Grant is combinational, so it is masked while reset is held.
  assign w_grant_en = (r_state == ST_IDLE) && w_found && !rst;
  assign grant      = w_grant_en ? (ONE_HOT0 << w_sel) : '0;
  assign rsp_valid  = (r_state == ST_RESP) ? (ONE_HOT0 << r_owner) : '0;
  assign busy       = (r_state != ST_IDLE);
  assign sine       = r_sine;
  assign cosine     = r_cosine;
endmodule

// File: tb/tb_trig_scheduler.sv
// Self-checking bench for trig_scheduler: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a transaction-level model.
module tb_trig_scheduler;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int VW = 21;
  localparam int P  = 3;

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b1;
  logic [N-1:0]         req      = '0;
  logic [N*AW-1:0]      angle_in = '0;
  logic [N-1:0]         rsp_ack  = '0;
  logic [N-1:0]         grant;
  logic [N-1:0]         rsp_valid;
  logic signed [VW-1:0] sine;
  logic signed [VW-1:0] cosine;
  logic                 busy;

  always #5 clk = ~clk;

  trig_scheduler #(
    .NUM_REQ (N),
    .PRECISE (P),
    .ANGLE_W (AW),
    .VAL_W   (VW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .angle_in  (angle_in),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_ack   (rsp_ack),
    .sine      (sine),
    .cosine    (cosine),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit           rs;
    logic [N-1:0] req;
    int           ang;
    logic [N-1:0] ack;
    logic [N-1:0] grant;
    logic [N-1:0] valid;
    bit           busy;
    bit           dchk;
    int           sine;
    int           cosine;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rs, logic [N-1:0] r, int a, logic [N-1:0] k,
                              logic [N-1:0] g, logic [N-1:0] v, bit b, bit d, int s, int c);
    vec_t t;
    t.rs = rs; t.req = r; t.ang = a; t.ack = k; t.grant = g; t.valid = v;
    t.busy = b; t.dchk = d; t.sine = s; t.cosine = c;
    return t;
  endfunction

  function automatic logic [N*AW-1:0] splat(int a);
    logic [N*AW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*AW +: AW] = AW'(a);
    return p;
  endfunction

  // Reference trig: real-valued math rounded half away from zero.
  function automatic int ref_trig(int a, bit use_cos);
    real rad;
    real v;
    rad = real'(a) * 3.14159265358979323846 / 180.0;
    v = use_cos ? $cos(rad) : $sin(rad);
    v = v * (10.0 ** P);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(string tag, logic [N-1:0] g, logic [N-1:0] v, bit b);
    chk({tag, " grant"}, grant, g);
    chk({tag, " rsp_valid"}, rsp_valid, v);
    chk({tag, " busy"}, busy, b);
  endtask

  task automatic chk_data(string tag, int s, int c);
    chk({tag, " sine"}, sine, s);
    chk({tag, " cosine"}, cosine, c);
  endtask

  task automatic drive(logic [N-1:0] r, logic [N*AW-1:0] pk, logic [N-1:0] k);
    @(negedge clk);
    req = r;
    angle_in = pk;
    rsp_ack = k;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    rsp_ack = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Transaction-level model state for the random phase.
  bit           m_busy;
  int           m_age;
  int           m_owner;
  int           m_ptr;
  int           m_angle;
  logic [N-1:0] r_r;
  logic [N-1:0] r_k;
  logic [N-1:0] e_g;
  logic [N-1:0] e_v;
  logic [N*AW-1:0] r_pk;
  int           r_ang [N];
  int           sel;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, with all requesters asserting to prove grant is held off.
    req = '1;
    angle_in = splat(45);
    #12;
    chk_ctl("reset", '0, '0, 1'b0);
    chk_data("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;

    // rs, req, ang, ack, grant, valid, busy, dchk, sine, cosine
    vecs.push_back(mk(0, 4'b0010,  30, 4'b0000, 4'b0010, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000,  30, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000,  30, 4'b0010, 4'b0000, 4'b0010, 1, 1,   500,   866));
    vecs.push_back(mk(0, 4'b0000,  30, 4'b0000, 4'b0000, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0001, -90, 4'b0000, 4'b0001, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000, -90, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000, -90, 4'b0001, 4'b0000, 4'b0001, 1, 1, -1000,     0));
    vecs.push_back(mk(0, 4'b0000, -90, 4'b0000, 4'b0000, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0100, 180, 4'b0000, 4'b0100, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000, 180, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000, 180, 4'b0100, 4'b0000, 4'b0100, 1, 1,     0, -1000));
    vecs.push_back(mk(0, 4'b0000, 180, 4'b0000, 4'b0000, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(1, 4'b1111,  45, 4'b0000, 4'b0001, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b1111, 4'b0000, 4'b0001, 1, 1,   707,   707));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b0010, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b1111, 4'b0000, 4'b0010, 1, 1,   707,   707));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b0100, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b1111, 4'b0000, 4'b0100, 1, 1,   707,   707));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b1000, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b1111,  45, 4'b1111, 4'b0000, 4'b1000, 1, 1,   707,   707));
    vecs.push_back(mk(0, 4'b0101,  45, 4'b0000, 4'b0001, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0101,  45, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0101,  45, 4'b0001, 4'b0000, 4'b0001, 1, 1,   707,   707));
    vecs.push_back(mk(0, 4'b0101,  45, 4'b0000, 4'b0100, 4'b0000, 0, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000,  45, 4'b0000, 4'b0000, 4'b0000, 1, 0,     0,     0));
    vecs.push_back(mk(0, 4'b0000,  45, 4'b0100, 4'b0000, 4'b0100, 1, 1,   707,   707));
    vecs.push_back(mk(0, 4'b0000,  45, 4'b0000, 4'b0000, 4'b0000, 0, 0,     0,     0));

    foreach (vecs[i]) begin
      if (vecs[i].rs) do_reset();
      drive(vecs[i].req, splat(vecs[i].ang), vecs[i].ack);
      chk_ctl($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid, vecs[i].busy);
      if (vecs[i].dchk) chk_data($sformatf("vec%0d", i), vecs[i].sine, vecs[i].cosine);
    end

    // Ack stall with stray acks and competing requests: response must hold.
    drive(4'b0010, splat(60), 4'b0000);
    chk_ctl("stall grant", 4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, splat(60), 4'b0000);
    chk_ctl("stall lookup", 4'b0000, 4'b0000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, splat(0), 4'b1101);
      chk_ctl($sformatf("stall%0d", c), 4'b0000, 4'b0010, 1'b1);
      chk_data($sformatf("stall%0d", c), 866, 500);
    end
    drive(4'b0000, splat(0), 4'b0010);
    chk_ctl("stall ack", 4'b0000, 4'b0010, 1'b1);
    drive(4'b0000, splat(0), 4'b0000);
    chk_ctl("stall done", 4'b0000, 4'b0000, 1'b0);

    // Reset during LOOKUP with requester 3 waiting.
    drive(4'b0001, splat(-30), 4'b0000);
    chk_ctl("rstmid grant", 4'b0001, 4'b0000, 1'b0);
    drive(4'b1000, splat(0), 4'b0000);
    chk_ctl("rstmid lookup", 4'b0000, 4'b0000, 1'b1);
    chk_data("rstmid held", 866, 500);
    #1 rst = 1'b1;
    #1;
    chk_ctl("rstmid async", 4'b0000, 4'b0000, 1'b0);
    chk_data("rstmid async", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ctl("rstmid regrant", 4'b1000, 4'b0000, 1'b0);
    drive(4'b0000, splat(0), 4'b0000);
    chk_ctl("rstmid lookup2", 4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, splat(0), 4'b1000);
    chk_ctl("rstmid resp", 4'b0000, 4'b1000, 1'b1);
    chk_data("rstmid resp", 0, 1000);
    drive(4'b0000, splat(0), 4'b0000);
    chk_ctl("rstmid idle", 4'b0000, 4'b0000, 1'b0);

    // Randomized traffic against the transaction model.
    do_reset();
    m_busy = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0; m_angle = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r_r = N'($urandom_range(0, 15));
      r_k = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 15)) : '0;
      for (int i = 0; i < N; i++) begin
        r_ang[i] = int'($urandom_range(0, 360)) - 180;
        r_pk[i*AW +: AW] = AW'(r_ang[i]);
      end
      drive(r_r, r_pk, r_k);
      sel = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (sel < 0 && r_r[(m_ptr + i) % N]) sel = (m_ptr + i) % N;
        end
      end
      e_g = (sel >= 0) ? (N'(1) << sel) : '0;
      e_v = (m_busy && m_age >= 2) ? (N'(1) << m_owner) : '0;
      chk_ctl($sformatf("rnd%0d", cyc), e_g, e_v, m_busy);
      if (e_v != '0)
        chk_data($sformatf("rnd%0d a=%0d", cyc, m_angle), ref_trig(m_angle, 1'b0), ref_trig(m_angle, 1'b1));
      if (sel >= 0) begin
        m_busy = 1'b1; m_age = 1; m_owner = sel; m_ptr = (sel + 1) % N; m_angle = r_ang[sel];
      end else if (m_busy) begin
        if (m_age >= 2 && r_k[m_owner]) m_busy = 1'b0;
        else m_age++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
